// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit imem words, then releases the CPU.
// Optional feature macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte before release.
module imem_loader #(
  parameter int ADDR_W       = 8,
  parameter int HDR_ZERO_MAX = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  input  logic              restart_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_rst_n_o,
  output logic              cpu_start_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_LAST = S_CHK;
`else
  localparam logic [2:0] S_LAST = S_DONE;
`endif

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_q;
  logic [ADDR_W:0]   target_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   words_nxt;
  logic [1:0]        idx_q;
  logic [23:0]       pack_p0;
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [31:0]       wr_data_p1;
  logic              run_q;
  logic              accept;
  logic [31:0]       hdr_ext;
  logic [ADDR_W:0]   hdr_n;
  logic              hdr_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign byte_ready_o = (state_q == S_HDR) || (state_q == S_DATA);
`endif
  assign accept    = byte_valid_i & byte_ready_o;
  assign words_nxt = words_q + {{ADDR_W{1'b0}}, 1'b1};

  // Header 0 is either a full-size image or an error; oversize headers are rejected.
  always_comb begin
    hdr_ext = {24'd0, byte_data_i};
    hdr_n   = hdr_ext[ADDR_W:0];
    hdr_bad = 1'b0;
    if (byte_data_i == 8'd0) begin
      hdr_n   = MAX_WORDS;
      hdr_bad = (HDR_ZERO_MAX == 0);
    end else if (hdr_ext > 32'(MAX_WORDS)) begin
      hdr_bad = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_HDR;
      target_q   <= '0;
      words_q    <= '0;
      idx_q      <= 2'd0;
      pack_p0    <= 24'd0;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= 32'd0;
      run_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      wr_vld_p1 <= 1'b0;
      if (restart_i && (state_q == S_DONE || state_q == S_ERR)) begin
        state_q  <= S_HDR;
        target_q <= '0;
        words_q  <= '0;
        idx_q    <= 2'd0;
        pack_p0  <= 24'd0;
        run_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_q    <= 8'd0;
`endif
      end else begin
        case (state_q)
          S_HDR: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
              chk_q <= byte_data_i;
`endif
              if (hdr_bad) begin
                state_q <= S_ERR;
              end else begin
                target_q <= hdr_n;
                state_q  <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
              chk_q <= chk_q ^ byte_data_i;
`endif
              // p0 -> p1: fourth byte completes the word and launches the write strobe
              if (idx_q == 2'd3) begin
                wr_vld_p1  <= 1'b1;
                wr_addr_p1 <= words_q[ADDR_W-1:0];
                wr_data_p1 <= {byte_data_i, pack_p0};
                idx_q      <= 2'd0;
                if (words_q != MAX_WORDS) words_q <= words_nxt;
                if (words_nxt == target_q) state_q <= S_LAST;
              end else begin
                case (idx_q)
                  2'd0:    pack_p0[7:0]   <= byte_data_i;
                  2'd1:    pack_p0[15:8]  <= byte_data_i;
                  default: pack_p0[23:16] <= byte_data_i;
                endcase
                idx_q <= idx_q + 2'd1;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHK: begin
            if (accept) state_q <= (byte_data_i == chk_q) ? S_DONE : S_ERR;
          end
`endif
          // Entered on the last strobe edge, so the CPU is released one cycle later.
          S_DONE: run_q <= 1'b1;
          S_ERR:  run_q <= 1'b0;
          default: state_q <= S_HDR;
        endcase
      end
    end
  end

  assign imem_we_o   = wr_vld_p1;
  assign imem_addr_o = wr_addr_p1;
  assign imem_data_o = wr_data_p1;
  assign cpu_rst_n_o = run_q;
  assign cpu_start_o = run_q;
  assign done_o      = run_q;
  assign err_o       = (state_q == S_ERR);
  assign words_o     = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed image loads checked against a byte-stream word model.
// Instance z uses HDR_ZERO_MAX=0 and shares all inputs with the main instance a.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n, byte_valid, restart;
  logic [7:0] byte_data;

  logic       a_ready, a_we, a_cpu_rst_n, a_start, a_done, a_err;
  logic [7:0] a_addr;
  logic [31:0] a_data;
  logic [8:0] a_words;
  logic       z_ready, z_we, z_cpu_rst_n, z_start, z_done, z_err;
  logic [7:0] z_addr;
  logic [31:0] z_data;
  logic [8:0] z_words;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int rise_cyc = -1;
  int z_we_cnt = 0;
  logic a_run_prev = 1'b0;
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  stream[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .HDR_ZERO_MAX(1)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(a_ready), .restart_i(restart), .imem_we_o(a_we), .imem_addr_o(a_addr),
    .imem_data_o(a_data), .cpu_rst_n_o(a_cpu_rst_n), .cpu_start_o(a_start),
    .done_o(a_done), .err_o(a_err), .words_o(a_words));

  imem_loader #(.ADDR_W(8), .HDR_ZERO_MAX(0)) dut_z (
    .clk_i(clk), .rst_i(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(z_ready), .restart_i(restart), .imem_we_o(z_we), .imem_addr_o(z_addr),
    .imem_data_o(z_data), .cpu_rst_n_o(z_cpu_rst_n), .cpu_start_o(z_start),
    .done_o(z_done), .err_o(z_err), .words_o(z_words));

  // Write log and release timing, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_we) begin
      wa_q.push_back(a_addr);
      wd_q.push_back(a_data);
      last_we_cyc = cyc;
    end
    if (z_we) z_we_cnt = z_we_cnt + 1;
    if (a_cpu_rst_n && !a_run_prev) rise_cyc = cyc;
    a_run_prev = a_cpu_rst_n;
  end

  function automatic logic [31:0] exp_word(input int k);
    return {stream[4*k+4], stream[4*k+3], stream[4*k+2], stream[4*k+1]};
  endfunction

  task automatic add_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'd0;
    foreach (stream[i]) x = x ^ stream[i];
    stream.push_back(x);
`endif
  endtask

  task automatic build_random(input int n);
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    add_chk();
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    last_we_cyc = -1;
    rise_cyc = -1;
    z_we_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; byte_valid = 1'b0; restart = 1'b0; byte_data = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic pulse_restart();
    @(negedge clk); #1 restart = 1'b1;
    @(negedge clk); #1 restart = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid 1,0,0 pattern, 2: random gaps.
  task automatic send_stream(input int first, input int last, input int mode, output bit ok);
    int i = first;
    int budget = (last - first) * 30 + 50;
    int pat = 0;
    logic v, rdy;
    while (i < last && budget > 0) begin
      @(negedge clk); #1;
      case (mode)
        0: v = 1'b1;
        1: v = (pat % 3 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      pat++;
      byte_valid = v;
      byte_data = v ? stream[i] : 8'($urandom);
      #1 rdy = a_ready;
      @(posedge clk);
      if (v && rdy) i++;
      budget--;
    end
    @(negedge clk); #1 byte_valid = 1'b0;
    ok = (i == last);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; byte_valid = 1'b0; restart = 1'b0; byte_data = 8'd0;
    #2;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    checks++; if (a_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", a_we); end
    checks++; if (a_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0h want=0", a_addr); end
    checks++; if (a_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h want=0", a_data); end
    checks++; if (a_cpu_rst_n !== 1'b0) begin failures++; $display("FAIL reset_cpu_rst_n got=%b want=0", a_cpu_rst_n); end
    checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", a_start); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", a_done); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", a_err); end
    checks++; if (a_words !== 9'd0) begin failures++; $display("FAIL reset_words got=%0d want=0", a_words); end
    checks++; if (z_err !== 1'b0) begin failures++; $display("FAIL reset_z_err got=%b want=0", z_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_basic_load();
    bit ok;
    stream = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    add_chk();
    clear_log();
    send_stream(0, stream.size(), 0, ok);
    idle(4);
    checks++; if (!ok) begin failures++; $display("FAIL basic_send_timeout got=stalled want=all bytes accepted"); end
    checks++; if (wa_q.size() !== 2) begin failures++; $display("FAIL basic_strobes got=%0d want=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'h00500013) begin failures++; $display("FAIL basic_word0 got=[%0h]=%h want=[0]=00500013", wa_q[0], wd_q[0]); end
      checks++; if (wa_q[1] !== 8'd1 || wd_q[1] !== 32'h00A00093) begin failures++; $display("FAIL basic_word1 got=[%0h]=%h want=[1]=00a00093", wa_q[1], wd_q[1]); end
    end
    checks++; if (a_words !== 9'd2) begin failures++; $display("FAIL basic_words got=%0d want=2", a_words); end
    checks++; if (a_done !== 1'b1 || a_cpu_rst_n !== 1'b1 || a_start !== 1'b1) begin failures++; $display("FAIL basic_release got=done%b rst_n%b start%b want=111", a_done, a_cpu_rst_n, a_start); end
`ifndef LOADER_CHECKSUM_EN
    checks++; if (rise_cyc - last_we_cyc !== 1) begin failures++; $display("FAIL basic_release_latency got=%0d want=1", rise_cyc - last_we_cyc); end
`endif
    // Trailing bytes must not be consumed once the image is complete.
    @(negedge clk); #1 byte_valid = 1'b1; byte_data = 8'h77;
    idle(3);
    checks++; if (a_ready !== 1'b0 || a_words !== 9'd2 || wa_q.size() !== 2) begin failures++; $display("FAIL basic_after_image got=ready%b words%0d strobes%0d want=ready0 words2 strobes2", a_ready, a_words, wa_q.size()); end
    byte_valid = 1'b0;
  endtask

  task automatic test_valid_toggle();
    bit ok;
    pulse_restart();
    clear_log();
    send_stream(0, stream.size(), 1, ok);
    idle(4);
    checks++; if (!ok || wa_q.size() !== 2) begin failures++; $display("FAIL toggle_strobes got=%0d want=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'h00500013 || wa_q[1] !== 8'd1 || wd_q[1] !== 32'h00A00093) begin
        failures++; $display("FAIL toggle_words got=[%0h]=%h [%0h]=%h want=[0]=00500013 [1]=00a00093", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
    checks++; if (a_done !== 1'b1 || a_words !== 9'd2) begin failures++; $display("FAIL toggle_done got=done%b words%0d want=done1 words2", a_done, a_words); end
  endtask

  task automatic test_random_loads();
    bit ok;
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 20);
      pulse_restart();
      build_random(n);
      clear_log();
      send_stream(0, stream.size(), 2, ok);
      idle(4);
      checks++; if (!ok || wa_q.size() !== n) begin failures++; $display("FAIL rand%0d_strobes got=%0d want=%0d", it, wa_q.size(), n); end
      for (int k = 0; k < n && k < wa_q.size(); k++) begin
        checks++;
        if (wa_q[k] !== 8'(k) || wd_q[k] !== exp_word(k)) begin
          failures++; $display("FAIL rand%0d_word%0d got=[%0h]=%h want=[%0h]=%h", it, k, wa_q[k], wd_q[k], k, exp_word(k));
        end
      end
      checks++; if (a_words !== 9'(n) || a_done !== 1'b1) begin failures++; $display("FAIL rand%0d_done got=words%0d done%b want=words%0d done1", it, a_words, a_done, n); end
    end
  endtask

  task automatic test_restart();
    bit ok1, ok2;
    // Restart with a byte offered in the same cycle: that byte must be dropped.
    @(negedge clk); #1 restart = 1'b1; byte_valid = 1'b1; byte_data = 8'h05;
    @(negedge clk); #1 restart = 1'b0; byte_valid = 1'b0;
    checks++; if (a_ready !== 1'b1 || a_cpu_rst_n !== 1'b0 || a_start !== 1'b0 || a_done !== 1'b0 || a_words !== 9'd0) begin
      failures++; $display("FAIL restart_state got=ready%b rst_n%b start%b done%b words%0d want=ready1 rst_n0 start0 done0 words0", a_ready, a_cpu_rst_n, a_start, a_done, a_words);
    end
    stream = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_chk();
    clear_log();
    send_stream(0, 3, 0, ok1);
    pulse_restart();
    send_stream(3, stream.size(), 0, ok2);
    idle(4);
    checks++; if (!ok1 || !ok2 || wa_q.size() !== 1) begin failures++; $display("FAIL restart_strobes got=%0d want=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'hDDCCBBAA) begin failures++; $display("FAIL restart_word got=[%0h]=%h want=[0]=ddccbbaa", wa_q[0], wd_q[0]); end
    end
    checks++; if (a_done !== 1'b1 || a_words !== 9'd1) begin failures++; $display("FAIL restart_done got=done%b words%0d want=done1 words1", a_done, a_words); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    pulse_restart();
    stream = '{8'h01, 8'h13, 8'h00, 8'h50, 8'h00, 8'h42};
    clear_log();
    send_stream(0, stream.size(), 2, ok);
    idle(4);
    checks++; if (!ok || a_done !== 1'b1 || a_err !== 1'b0) begin failures++; $display("FAIL chk_match got=done%b err%b want=done1 err0", a_done, a_err); end
    pulse_restart();
    stream = '{8'h01, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
    clear_log();
    send_stream(0, stream.size(), 0, ok);
    idle(4);
    checks++; if (!ok || a_err !== 1'b1 || a_done !== 1'b0 || a_cpu_rst_n !== 1'b0) begin failures++; $display("FAIL chk_mismatch got=err%b done%b rst_n%b want=err1 done0 rst_n0", a_err, a_done, a_cpu_rst_n); end
    checks++; if (wa_q.size() !== 1 || wd_q[0] !== 32'h00500013) begin failures++; $display("FAIL chk_mismatch_write got=%0d strobes want=1 strobe of 00500013", wa_q.size()); end
  endtask
`endif

  task automatic test_zero_header();
    bit ok;
    int bad = 0;
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    for (int i = 0; i < 1024; i++) stream.push_back(8'($urandom));
    add_chk();
    send_stream(0, stream.size(), 0, ok);
    idle(4);
    checks++; if (!ok || wa_q.size() !== 256) begin failures++; $display("FAIL zero_strobes got=%0d want=256", wa_q.size()); end
    if (wa_q.size() == 256) begin
      for (int k = 0; k < 256; k++) if (wa_q[k] !== 8'(k) || wd_q[k] !== exp_word(k)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL zero_words got=%0d bad words want=0", bad); end
      checks++; if (wa_q[255] !== 8'd255) begin failures++; $display("FAIL zero_last_addr got=%0d want=255", wa_q[255]); end
    end
    checks++; if (a_done !== 1'b1 || a_words !== 9'd256) begin failures++; $display("FAIL zero_done got=done%b words%0d want=done1 words256", a_done, a_words); end
    checks++; if (z_err !== 1'b1 || z_we_cnt !== 0 || z_cpu_rst_n !== 1'b0) begin failures++; $display("FAIL zero_err_variant got=err%b strobes%0d rst_n%b want=err1 strobes0 rst_n0", z_err, z_we_cnt, z_cpu_rst_n); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    build_random(3);
    send_stream(0, 7, 2, ok);
    idle(2);
    checks++; if (!ok || wa_q.size() !== 1 || a_words !== 9'd1) begin failures++; $display("FAIL areset_pre got=strobes%0d words%0d want=strobes1 words1", wa_q.size(), a_words); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (a_we !== 1'b0 || a_addr !== 8'd0 || a_data !== 32'd0 || a_words !== 9'd0 || a_ready !== 1'b1 || a_cpu_rst_n !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0) begin
      failures++; $display("FAIL areset_outputs got=we%b addr%0h data%h words%0d ready%b rst_n%b done%b err%b want=reset values", a_we, a_addr, a_data, a_words, a_ready, a_cpu_rst_n, a_done, a_err);
    end
    @(negedge clk); rst_n = 1'b1;
    build_random(1);
    clear_log();
    send_stream(0, stream.size(), 2, ok);
    idle(4);
    checks++; if (!ok || wa_q.size() !== 1) begin failures++; $display("FAIL areset_reload_strobes got=%0d want=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== exp_word(0)) begin failures++; $display("FAIL areset_reload_word got=[%0h]=%h want=[0]=%h", wa_q[0], wd_q[0], exp_word(0)); end
    end
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL areset_reload_done got=%b want=1", a_done); end
  endtask

  initial begin
    rst_n = 1'b0; byte_valid = 1'b0; restart = 1'b0; byte_data = 8'd0;
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_random_loads();
    test_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_zero_header();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
